alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 3-bit signed arithmetic unit: ADD, SUB, MUL and REM on two's-complement operands A and B, selected by S.
- Produces a 5-bit signed result plus status flags (sign, zero, divide-by-zero, error, overflow).
- Execute stage of the 3-bit signed calculator; operands come from the keypad/decoder front end, and results feed the display stage.

Parameters:
- None. Widths are fixed: operands 3 bits, result 5 bits; constants come from alu_pkg.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and opcode are valid this cycle
- A  input  3  operand A, two's complement, range -4..3
- B  input  3  operand B, two's complement, range -4..3
- S  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 REM
- out_valid  output  1  R and flags updated this cycle
- R  output  5  signed result, two's complement
- SF  output  1  sign flag, equals R[4]
- ZF  output  1  zero flag
- DZF  output  1  divide-by-zero flag
- EF  output  1  error flag
- OF  output  1  overflow flag

Behaviour:
- Reset: on a rising clk with rst=1, all outputs clear to 0 (out_valid, R, SF, ZF, DZF, EF, OF). rst has priority over in_valid.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, results appear after edge N and out_valid=1 for that one cycle.
- When in_valid=0, out_valid drops to 0. R and the flags hold their previous values.
- No backpressure. A new operation can be accepted every cycle.
- Arithmetic: sign-extend A and B to 5 bits, then compute:
  - ADD: R=A+B, range -8..6
  - SUB: R=A-B, range -7..7
  - MUL: R=A*B, range -12..16
  - REM: truncating remainder; the result takes the sign of the dividend and |R|<|B|. Examples: -3 rem 2 = -1; 3 rem -2 = 1; -4 rem 3 = -1.
- The single unrepresentable case is MUL with A=B=-4 (true value 16):
  - R=5'b10000 (wraps to -16)
  - EF=1, OF=1
- REM with B=0:
  - R=0, DZF=1, EF=1, ZF=0
  - SF=0, OF=0
- DZF is asserted only for REM with B=0; B=0 under any other opcode gives DZF=0.
- OF=1 when the true mathematical result lies outside the 3-bit signed range -4..3, so the result cannot be written back as an operand. Never set when DZF=1.
- EF = DZF OR (true result outside the 5-bit range -16..15).
- ZF=1 iff R==0 and EF=0.
- SF = R[4] in all cases, except that it is forced to 0 when DZF=1.
- All flags are registered together with R in the same cycle.

Optional Feature:
- Macro: ALU_STICKY_ERR_EN.
- When defined:
  - Adds output port err_sticky (1 bit).
  - err_sticky is set on any cycle where the registered EF becomes 1.
  - It stays set until rst; reset value 0.
- When undefined: the port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - enum alu_op_e (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_REM=2'b11)
  - localparams OPND_W=3 and RES_W=5
  - localparams OPND_MIN=-4, OPND_MAX=3, RES_MIN=-16, RES_MAX=15
- One sub-module, alu_rem3: a combinational signed truncating remainder with a divide-by-zero output. It is instantiated once inside alu.
- ADD, SUB, MUL, the flag logic and the output register live in alu.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles with in_valid=1, S=00, A=3, B=3 -> all outputs 0. After releasing rst, one more edge -> R=6, OF=1, SF=0, ZF=0, out_valid=1.
- SUB to zero: S=01, A=-3, B=-3 -> R=0, ZF=1, SF=0, OF=0, EF=0, one cycle after in_valid.
- MUL cases:
  - S=10, A=3, B=-3 -> R=-9 (5'b10111), SF=1, OF=1, EF=0.
  - S=10, A=-4, B=-4 -> R=5'b10000, OF=1, EF=1.
- REM with B=0: S=11, A=3, B=0 -> R=0, DZF=1, EF=1, ZF=0, SF=0, OF=0.
- REM sign: S=11, (A=-3, B=2) -> R=-1, SF=1; (A=3, B=-2) -> R=1, SF=0; DZF=0 in both.
- Hold behaviour: after any result, in_valid=0 for 3 cycles with changing A/B/S -> out_valid=0, R and flags unchanged. Full sweep A,B in -4..3 for all four opcodes matches a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the 3-bit signed calculator execute stage.
package alu_pkg;

  localparam int OPND_W   = 3;
  localparam int RES_W    = 5;
  localparam int OPND_MIN = -4;
  localparam int OPND_MAX = 3;
  localparam int RES_MIN  = -16;
  localparam int RES_MAX  = 15;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_REM = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic sf;
    logic zf;
    logic dzf;
    logic ef;
    logic of;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the decoder front end, the ALU and the display stage.
interface alu_if;
  import alu_pkg::*;

  logic              in_valid;
  logic [OPND_W-1:0] A;
  logic [OPND_W-1:0] B;
  logic [1:0]        S;
  logic              out_valid;
  logic [RES_W-1:0]  R;
  logic              SF;
  logic              ZF;
  logic              DZF;
  logic              EF;
  logic              OF;

  modport master (
    output in_valid, A, B, S,
    input  out_valid, R, SF, ZF, DZF, EF, OF
  );

  modport slave (
    input  in_valid, A, B, S,
    output out_valid, R, SF, ZF, DZF, EF, OF
  );

endinterface

// File: rtl/alu_rem3.sv
// Combinational signed truncating remainder of two 3-bit operands.
// The result takes the dividend's sign; a zero divisor yields 0 with dz_o set.
module alu_rem3
  import alu_pkg::*;
(
  input  logic signed [OPND_W-1:0] a_i,
  input  logic signed [OPND_W-1:0] b_i,
  output logic signed [OPND_W-1:0] rem_o,
  output logic                     dz_o
);

  // Remainder with zero-divisor guard so the modulo never sees B=0
  always_comb begin
    dz_o = (b_i == 3'sd0);
    if (dz_o) begin
      rem_o = 3'sd0;
    end else begin
      rem_o = a_i % b_i;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered 3-bit signed ALU (ADD/SUB/MUL/REM) with 5-bit result and status flags.
// Optional build macro ALU_STICKY_ERR_EN adds the err_sticky output.
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
`ifdef ALU_STICKY_ERR_EN
  ,
  output logic err_sticky
`endif
);

  // One extra bit over the result width holds every true value (-12..16) exactly.
  localparam int TRUE_W = RES_W + 1;
  localparam logic signed [TRUE_W-1:0] OPND_MIN_T = TRUE_W'(OPND_MIN);
  localparam logic signed [TRUE_W-1:0] OPND_MAX_T = TRUE_W'(OPND_MAX);
  localparam logic signed [TRUE_W-1:0] RES_MIN_T  = TRUE_W'(RES_MIN);
  localparam logic signed [TRUE_W-1:0] RES_MAX_T  = TRUE_W'(RES_MAX);

  alu_op_e                    op_s;
  logic signed [TRUE_W-1:0]   a_ext_s;
  logic signed [TRUE_W-1:0]   b_ext_s;
  logic signed [TRUE_W-1:0]   true_s;
  logic signed [OPND_W-1:0]   rem_s;
  logic                       dz_s;
  logic                       dz_op_s;
  logic [RES_W-1:0]           res_s;
  alu_flags_t                 flags_s;

  logic                       out_valid_d, out_valid_q;
  logic [RES_W-1:0]           r_d, r_q;
  alu_flags_t                 flags_d, flags_q;

  alu_rem3 u_rem3 (
    .a_i   (bus.A),
    .b_i   (bus.B),
    .rem_o (rem_s),
    .dz_o  (dz_s)
  );

  // Exact arithmetic result in the widened domain
  always_comb begin
    a_ext_s = TRUE_W'($signed(bus.A));
    b_ext_s = TRUE_W'($signed(bus.B));
    op_s    = alu_op_e'(bus.S);
    true_s  = '0;
    dz_op_s = 1'b0;
    case (op_s)
      OP_ADD: true_s = a_ext_s + b_ext_s;
      OP_SUB: true_s = a_ext_s - b_ext_s;
      OP_MUL: true_s = a_ext_s * b_ext_s;
      OP_REM: begin
        true_s  = TRUE_W'(rem_s);
        dz_op_s = dz_s;
      end
      default: true_s = '0;
    endcase
  end

  // Result truncation and status flags; divide-by-zero overrides R, SF and OF
  always_comb begin
    res_s       = dz_op_s ? '0 : true_s[RES_W-1:0];
    flags_s.dzf = dz_op_s;
    flags_s.of  = !dz_op_s && ((true_s < OPND_MIN_T) || (true_s > OPND_MAX_T));
    flags_s.ef  = dz_op_s || (true_s < RES_MIN_T) || (true_s > RES_MAX_T);
    flags_s.zf  = (res_s == '0) && !flags_s.ef;
    flags_s.sf  = res_s[RES_W-1] && !dz_op_s;
  end

  // Next-state: load on in_valid, otherwise hold R/flags and drop out_valid
  always_comb begin
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      r_d     = res_s;
      flags_d = flags_s;
    end else begin
      r_d     = r_q;
      flags_d = flags_q;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign bus.SF        = flags_q.sf;
  assign bus.ZF        = flags_q.zf;
  assign bus.DZF       = flags_q.dzf;
  assign bus.EF        = flags_q.ef;
  assign bus.OF        = flags_q.of;

`ifdef ALU_STICKY_ERR_EN
  logic err_sticky_d, err_sticky_q;

  // Sticky error latches in the same edge that loads EF=1
  always_comb begin
    err_sticky_d = err_sticky_q | (bus.in_valid & flags_s.ef);
  end

  // Sticky error register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps plus a full operand sweep, scoreboard-checked.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  alu_if bus();

`ifdef ALU_STICKY_ERR_EN
  logic err_sticky;
  logic sticky_m;
`endif

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_STICKY_ERR_EN
    ,
    .err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [10:0] sb_q[$];
  logic [10:0] last_exp;

  // Packed view: {out_valid, R[4:0], SF, ZF, DZF, EF, OF}
  function automatic logic [10:0] observed();
    return {bus.out_valid, bus.R, bus.SF, bus.ZF, bus.DZF, bus.EF, bus.OF};
  endfunction

  function automatic logic [10:0] model(int a, int b, int s);
    int t;
    logic dz, sf, zf, ef, of;
    logic [4:0] r;
    dz = 1'b0;
    t  = 0;
    case (s)
      0: t = a + b;
      1: t = a - b;
      2: t = a * b;
      default: begin
        if (b == 0) dz = 1'b1;
        else        t = a - (a / b) * b;
      end
    endcase
    r  = dz ? 5'd0 : 5'(t);
    of = !dz && (t < -4 || t > 3);
    ef = dz || (t < -16) || (t > 15);
    zf = (r == 5'd0) && !ef;
    sf = r[4] && !dz;
    return {1'b1, r, sf, zf, dz, ef, of};
  endfunction

  task automatic check(string tag, logic [10:0] got, logic [10:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic apply(string tag, logic v, int a, int b, int s, logic [10:0] exp);
    @(negedge clk);
    bus.in_valid = v;
    bus.A        = 3'(a);
    bus.B        = 3'(b);
    bus.S        = 2'(s);
    if (v) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (v) begin
      last_exp = sb_q.pop_front();
      check(tag, observed(), last_exp);
    end else begin
      check(tag, observed(), {1'b0, last_exp[9:0]});
    end
`ifdef ALU_STICKY_ERR_EN
    if (v) sticky_m = sticky_m | last_exp[1];
    check({tag, "_sticky"}, {10'd0, err_sticky}, {10'd0, sticky_m});
`endif
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 3'd3;
    bus.B        = 3'd3;
    bus.S        = 2'b00;
    last_exp     = 11'd0;
`ifdef ALU_STICKY_ERR_EN
    sticky_m     = 1'b0;
`endif

    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset", observed(), 11'd0);
    end
    rst = 1'b0;

    apply("add_3_3",     1'b1,  3,  3, 0, {1'b1, 5'd6,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    apply("sub_zero",    1'b1, -3, -3, 1, {1'b1, 5'd0,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    apply("mul_3_m3",    1'b1,  3, -3, 2, {1'b1, 5'b10111,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    apply("mul_m4_m4",   1'b1, -4, -4, 2, {1'b1, 5'b10000,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    apply("hold0",       1'b0,  1,  2, 3, 11'd0);
    apply("hold1",       1'b0, -2,  0, 0, 11'd0);
    apply("hold2",       1'b0,  3, -1, 1, 11'd0);
    apply("rem_div0",    1'b1,  3,  0, 3, {1'b1, 5'd0,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    apply("rem_m3_2",    1'b1, -3,  2, 3, {1'b1, 5'b11111,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    apply("rem_3_m2",    1'b1,  3, -2, 3, {1'b1, 5'd1,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    apply("rem_m4_3",    1'b1, -4,  3, 3, {1'b1, 5'b11111,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    apply("add_m4_m4",   1'b1, -4, -4, 0, {1'b1, 5'b11000,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    apply("add_b0",      1'b1,  3,  0, 0, {1'b1, 5'd3,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    apply("mul_b0",      1'b1, -4,  0, 2, {1'b1, 5'd0,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    apply("hold3",       1'b0,  2,  2, 2, 11'd0);
    apply("hold4",       1'b0, -1,  0, 3, 11'd0);
    apply("hold5",       1'b0,  0,  3, 1, 11'd0);

    for (int s = 0; s < 4; s++) begin
      for (int a = -4; a <= 3; a++) begin
        for (int b = -4; b <= 3; b++) begin
          apply($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), 1'b1, a, b, s, model(a, b, s));
        end
      end
    end

    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("reset_late", observed(), 11'd0);
`ifdef ALU_STICKY_ERR_EN
    check("reset_late_sticky", {10'd0, err_sticky}, 11'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
